// File: rtl/cdf_build.sv
// Builds a 256-bin histogram of 8-bit pixels read from the image scratchpad,
// then streams the cumulative distribution to M2SP and reports CdfMin/divisor.
module cdf_build #(
    parameter logic [15:0] CDF_BASE = 16'h0000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  input_base,
    input  logic [15:0]  word_count,
    output logic [15:0]  InputSP_ReadAddress,
    input  logic [127:0] InputSP_ReadBus,
    output logic         M2SP_WriteEnable,
    output logic [15:0]  M2SP_WriteAddress,
    output logic [127:0] M2SP_WriteBus,
    output logic [19:0]  CdfMin,
    output logic [19:0]  divisor,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_COUNT,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   base_q, base_d;
    logic [15:0]   nwords_q, nwords_d;
    logic [15:0]   widx_q, widx_d;
    logic [15:0]   rd_addr_q, rd_addr_d;
    logic [127:0]  word_q, word_d;
    logic [3:0]    byte_q, byte_d;
    logic [7:0]    bidx_q, bidx_d;
    logic [19:0]   sum_q, sum_d;
    logic [19:0]   min_q, min_d;
    logic [19:0]   div_q, div_d;
    logic          min_found_q, min_found_d;
    logic [19:0]   bin_q [256];
    logic [19:0]   bin_d [256];

    logic [7:0]    pixel;
    logic [19:0]   new_sum;
    logic [15:0]   widx_inc;

    always_comb begin
        pixel       = word_q[{byte_q, 3'b000} +: 8];
        new_sum     = sum_q + bin_q[bidx_q];
        widx_inc    = widx_q + 16'd1;

        state_d     = state_q;
        base_d      = base_q;
        nwords_d    = nwords_q;
        widx_d      = widx_q;
        rd_addr_d   = rd_addr_q;
        word_d      = word_q;
        byte_d      = byte_q;
        bidx_d      = bidx_q;
        sum_d       = sum_q;
        min_d       = min_q;
        div_d       = div_q;
        min_found_d = min_found_q;
        bin_d       = bin_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d      = input_base;
                    nwords_d    = word_count;
                    widx_d      = '0;
                    bidx_d      = '0;
                    sum_d       = '0;
                    min_d       = '0;
                    div_d       = '0;
                    min_found_d = 1'b0;
                    bin_d       = '{default: '0};
                    if (word_count == 16'd0) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d   = ST_READ;
                        rd_addr_d = input_base;
                    end
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                word_d  = InputSP_ReadBus;
                byte_d  = '0;
                state_d = ST_COUNT;
            end
            ST_COUNT: begin
                bin_d[pixel] = bin_q[pixel] + 20'd1;
                byte_d       = byte_q + 4'd1;
                if (byte_q == 4'd15) begin
                    widx_d = widx_inc;
                    if (widx_inc == nwords_q) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d   = ST_READ;
                        rd_addr_d = base_q + widx_inc;
                    end
                end
            end
            ST_SCAN: begin
                sum_d  = new_sum;
                bidx_d = bidx_q + 8'd1;
                if (!min_found_q && new_sum != '0) begin
                    min_d       = new_sum;
                    min_found_d = 1'b1;
                end
                // min_d already reflects a minimum found on this final bin
                if (bidx_q == 8'd255) begin
                    div_d   = new_sum - min_d;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            nwords_q    <= '0;
            widx_q      <= '0;
            rd_addr_q   <= '0;
            word_q      <= '0;
            byte_q      <= '0;
            bidx_q      <= '0;
            sum_q       <= '0;
            min_q       <= '0;
            div_q       <= '0;
            min_found_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            nwords_q    <= nwords_d;
            widx_q      <= widx_d;
            rd_addr_q   <= rd_addr_d;
            word_q      <= word_d;
            byte_q      <= byte_d;
            bidx_q      <= bidx_d;
            sum_q       <= sum_d;
            min_q       <= min_d;
            div_q       <= div_d;
            min_found_q <= min_found_d;
        end
    end

    // Bin contents are don't-care after reset; start clears them.
    always_ff @(posedge clock) begin
        bin_q <= bin_d;
    end

    assign InputSP_ReadAddress = rd_addr_q;
    assign M2SP_WriteEnable    = (state_q == ST_SCAN);
    assign M2SP_WriteAddress   = (state_q == ST_SCAN) ? CDF_BASE + {8'h00, bidx_q} : '0;
    assign M2SP_WriteBus       = (state_q == ST_SCAN) ? {108'b0, new_sum} : '0;
    assign CdfMin              = min_q;
    assign divisor             = div_q;
    assign busy                = (state_q != ST_IDLE);
    assign done                = (state_q == ST_DONE);

endmodule
